// File: rtl/fir_ctrl_registers.sv
// Host-visible control/status register bank of the FIR accelerator.
// Holds Start and the filter configuration; returns engine status on a combinational read bus.
module fir_ctrl_registers (
  input  logic        clk_b,
  input  logic        rst_n,
  input  logic [15:0] CDC_data,
  input  logic [2:0]  nr_Rejestru,
  input  logic        wr_Rej,
  input  logic        Pracuje,
  input  logic        DONE,
  output logic [15:0] Rej_out,
  output logic        Start,
  output logic [5:0]  Ile_wsp,
  output logic [13:0] Ile_probek
);

  localparam logic [2:0] ADDR_START   = 3'b000;
  localparam logic [2:0] ADDR_DONE    = 3'b001;
  localparam logic [2:0] ADDR_PRACUJE = 3'b010;
  localparam logic [2:0] ADDR_ILE_WSP = 3'b011;
  localparam logic [2:0] ADDR_ILE_PRB = 3'b100;

  logic        start_q, start_d;
  logic [5:0]  ile_wsp_q, ile_wsp_d;
  logic [13:0] ile_probek_q, ile_probek_d;
  logic [15:0] rej_out;

  // A host write to START beats the engine acknowledge in the same cycle.
  always_comb begin
    start_d      = start_q;
    ile_wsp_d    = ile_wsp_q;
    ile_probek_d = ile_probek_q;
    if (wr_Rej && nr_Rejestru == ADDR_START) begin
      start_d = CDC_data[0];
    end else if (Pracuje) begin
      start_d = 1'b0;
    end
    if (wr_Rej && nr_Rejestru == ADDR_ILE_WSP) begin
      ile_wsp_d = CDC_data[5:0];
    end
    if (wr_Rej && nr_Rejestru == ADDR_ILE_PRB) begin
      ile_probek_d = CDC_data[13:0];
    end
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      start_q      <= 1'b0;
      ile_wsp_q    <= 6'd0;
      ile_probek_q <= 14'd0;
    end else begin
      start_q      <= start_d;
      ile_wsp_q    <= ile_wsp_d;
      ile_probek_q <= ile_probek_d;
    end
  end

  always_comb begin
    rej_out = 16'h0000;
    case (nr_Rejestru)
      ADDR_START:   rej_out = {15'b0, start_q};
      ADDR_DONE:    rej_out = {15'b0, DONE};
      ADDR_PRACUJE: rej_out = {15'b0, Pracuje};
      ADDR_ILE_WSP: rej_out = {10'b0, ile_wsp_q};
      ADDR_ILE_PRB: rej_out = {2'b0, ile_probek_q};
      default:      rej_out = 16'h0000;
    endcase
  end

  assign Rej_out    = rej_out;
  assign Start      = start_q;
  assign Ile_wsp    = ile_wsp_q;
  assign Ile_probek = ile_probek_q;

endmodule

// File: tb/tb_fir_ctrl_registers.sv
// Directed bench for fir_ctrl_registers: inputs driven and outputs sampled on the falling edge.
module tb_fir_ctrl_registers;

  logic        clk_b = 1'b0;
  logic        rst_n;
  logic [15:0] CDC_data;
  logic [2:0]  nr_Rejestru;
  logic        wr_Rej;
  logic        Pracuje;
  logic        DONE;
  logic [15:0] Rej_out;
  logic        Start;
  logic [5:0]  Ile_wsp;
  logic [13:0] Ile_probek;

  int checks   = 0;
  int failures = 0;

  fir_ctrl_registers dut (
    .clk_b      (clk_b),
    .rst_n      (rst_n),
    .CDC_data   (CDC_data),
    .nr_Rejestru(nr_Rejestru),
    .wr_Rej     (wr_Rej),
    .Pracuje    (Pracuje),
    .DONE       (DONE),
    .Rej_out    (Rej_out),
    .Start      (Start),
    .Ile_wsp    (Ile_wsp),
    .Ile_probek (Ile_probek)
  );

  always #5 clk_b = ~clk_b;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 16'h%04h expected 16'h%04h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk_b);
    nr_Rejestru = a;
    CDC_data    = d;
    wr_Rej      = 1'b1;
    @(negedge clk_b);
    wr_Rej      = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    nr_Rejestru = a;
    #1;
    check_val(tag, Rej_out, exp);
  endtask

  initial begin
    logic [2:0] ro_addrs [5];
    ro_addrs = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7};

    rst_n = 1'b0; CDC_data = 16'h0; nr_Rejestru = 3'd0; wr_Rej = 1'b0;
    Pracuje = 1'b0; DONE = 1'b0;
    repeat (2) @(negedge clk_b);
    check_val("rst_start", {15'b0, Start}, 16'h0);
    check_val("rst_wsp", {10'b0, Ile_wsp}, 16'h0);
    check_val("rst_probek", {2'b0, Ile_probek}, 16'h0);
    rd_chk("rst_rd000", 3'd0, 16'h0);
    rd_chk("rst_rd011", 3'd3, 16'h0);
    rd_chk("rst_rd100", 3'd4, 16'h0);
    DONE = 1'b1;
    rd_chk("rst_rd001_live", 3'd1, 16'h0001);
    DONE = 1'b0;
    @(negedge clk_b);
    rst_n = 1'b1;

    // Start set, then cleared by engine acknowledge
    wr_reg(3'd0, 16'h0001);
    check_val("start_set", {15'b0, Start}, 16'h0001);
    rd_chk("start_rd", 3'd0, 16'h0001);
    Pracuje = 1'b1;
    #1;
    check_val("start_before_ack_edge", {15'b0, Start}, 16'h0001);
    @(negedge clk_b);
    check_val("start_ack_clear", {15'b0, Start}, 16'h0);
    // Write has priority over acknowledge in the same cycle
    wr_reg(3'd0, 16'hFFFF);
    check_val("start_wr_priority", {15'b0, Start}, 16'h0001);
    @(negedge clk_b);
    check_val("start_ack_clear2", {15'b0, Start}, 16'h0);
    Pracuje = 1'b0;
    wr_reg(3'd0, 16'h0001);
    wr_reg(3'd0, 16'h0000);
    check_val("start_explicit_clear", {15'b0, Start}, 16'h0);

    wr_reg(3'd3, 16'd45);
    check_val("wsp_45", {10'b0, Ile_wsp}, 16'd45);
    rd_chk("wsp_rd_45", 3'd3, 16'h002D);
    wr_reg(3'd3, 16'hFFFF);
    check_val("wsp_trunc", {10'b0, Ile_wsp}, 16'd63);
    rd_chk("wsp_rd_trunc", 3'd3, 16'h003F);

    wr_reg(3'd4, 16'd1024);
    check_val("probek_1024", {2'b0, Ile_probek}, 16'd1024);
    rd_chk("probek_rd_1024", 3'd4, 16'h0400);
    wr_reg(3'd4, 16'hFFFF);
    check_val("probek_trunc", {2'b0, Ile_probek}, 16'h3FFF);
    rd_chk("probek_rd_trunc", 3'd4, 16'h3FFF);

    // Back-to-back writes, last one wins
    @(negedge clk_b);
    nr_Rejestru = 3'd3; CDC_data = 16'd5; wr_Rej = 1'b1;
    @(negedge clk_b);
    check_val("b2b_first", {10'b0, Ile_wsp}, 16'd5);
    CDC_data = 16'd9;
    @(negedge clk_b);
    wr_Rej = 1'b0;
    check_val("b2b_second", {10'b0, Ile_wsp}, 16'd9);
    nr_Rejestru = 3'd4; CDC_data = 16'd7; wr_Rej = 1'b1;
    @(negedge clk_b);
    wr_Rej = 1'b0;
    check_val("b2b_other_addr", {2'b0, Ile_probek}, 16'd7);
    check_val("b2b_wsp_kept", {10'b0, Ile_wsp}, 16'd9);

    Pracuje = 1'b1; DONE = 1'b1;
    rd_chk("stat_done", 3'd1, 16'h0001);
    rd_chk("stat_pracuje", 3'd2, 16'h0001);
    DONE = 1'b0;
    rd_chk("stat_done_drop", 3'd1, 16'h0000);
    Pracuje = 1'b0;
    rd_chk("stat_pracuje_drop", 3'd2, 16'h0000);

    // Writes to RO/reserved addresses must not disturb anything
    wr_reg(3'd0, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      wr_reg(ro_addrs[i], 16'hFFFF);
      check_val($sformatf("ro_start_a%0d", ro_addrs[i]), {15'b0, Start}, 16'h0001);
      check_val($sformatf("ro_wsp_a%0d", ro_addrs[i]), {10'b0, Ile_wsp}, 16'd9);
      check_val($sformatf("ro_probek_a%0d", ro_addrs[i]), {2'b0, Ile_probek}, 16'd7);
      if (ro_addrs[i] > 3'd4) rd_chk($sformatf("rsvd_rd_a%0d", ro_addrs[i]), ro_addrs[i], 16'h0);
    end

    // Asynchronous reset mid-operation
    @(posedge clk_b);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_start", {15'b0, Start}, 16'h0);
    check_val("async_wsp", {10'b0, Ile_wsp}, 16'h0);
    check_val("async_probek", {2'b0, Ile_probek}, 16'h0);
    rd_chk("async_rd011", 3'd3, 16'h0);
    @(negedge clk_b);
    rst_n = 1'b1;
    wr_reg(3'd3, 16'd12);
    check_val("post_reset_write", {10'b0, Ile_wsp}, 16'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
